fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arb_rr_pick.sv | 46 ++++
 rtl/fifo_wr_arb.sv | 207 ++++++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg
// Shared definitions for the fifo write arbiter: the arbiter FSM state
// type, the statistics counter width and a small index helper.
package fifo_wr_arb_pkg;

    // Arbiter FSM: IDLE owns nothing, BUSY streams beats from one owner.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Width of each per-requester accepted-beat counter.
    localparam int STAT_W = 16;

    // Circular increment of a requester index in the range 0..n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick
// Combinational round-robin priority search. Starting at index 'start'
// and wrapping around, returns the first set bit of 'req'.
//
// Parameters:
//   N  - number of request lines
//   IW - index width
// Ports:
//   req   - request vector
//   start - index that gets highest priority
//   valid - at least one request is set
//   idx   - index of the selected request (0 when valid is low)
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Walk all N positions from 'start'; the first hit wins.
    always_comb begin
        int          cand;
        logic [IW-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        valid    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(start) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
// Round-robin write arbiter in front of a single fifo. One requester at a
// time owns the fifo write port for up to BURST accepted beats; ownership
// is released early when the owner drops its request. Re-arbitration on
// release happens in the same edge, so there is no idle bubble between
// bursts, and the previous owner gets lowest priority.
//
// Optional feature (macro FIFO_WR_ARB_STATS_EN): one saturating 16-bit
// accepted-beat counter per requester. Without the macro, stats_o is tied
// to zero and stats_clr_i is ignored.
//
// Parameters:
//   WIDTH - data word width (matches the fifo)
//   N_REQ - number of requesters (2..16)
//   BURST - maximum accepted beats per grant (1..256)
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - asynchronous active-low reset
//   req_i        - per-requester write request
//   data_i       - requester k's word at [k*WIDTH +: WIDTH]
//   fifo_full_i  - fifo full flag
//   gnt_o        - registered one-hot owner, zero when idle
//   ack_o        - combinational per-requester beat accepted
//   fifo_wr_en_o - fifo write enable
//   fifo_data_o  - fifo write data (owner's word, zero when idle)
//   stats_clr_i  - synchronous clear of the statistics counters
//   stats_o      - per-requester accepted-beat counters, 16 bits each
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int BURST = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*WIDTH-1:0]  data_i,
    input  logic                    fifo_full_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        ack_o,
    output logic                    fifo_wr_en_o,
    output logic [WIDTH-1:0]        fifo_data_o,
    input  logic                    stats_clr_i,
    output logic [N_REQ*STAT_W-1:0] stats_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(BURST) + 1;
    localparam logic [IW-1:0]    LAST_IDX  = IW'(N_REQ - 1);
    localparam logic [BW-1:0]    BURST_LEN = BW'(BURST);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_q,  last_d;
    logic [BW-1:0]     beat_q,  beat_d;
    logic [N_REQ-1:0]  gnt_q,   gnt_d;

    logic [IW-1:0]     pick_base;
    logic [IW-1:0]     pick_start;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [BW-1:0]     beat_inc;
    logic              owner_req;
    logic              release_now;

    // A beat is accepted only for the granted requester while the fifo has room.
    assign ack_o        = gnt_q & req_i & {N_REQ{~fifo_full_i}};
    assign fifo_wr_en_o = |ack_o;
    assign gnt_o        = gnt_q;

    assign owner_req = req_i[owner_q];
    assign beat_inc  = beat_q + BW'(1);

    // In BUSY a release makes the current owner the new last_owner, so the
    // search always starts one past whichever index is "last" right now.
    assign pick_base  = (state_q == BUSY) ? owner_q : last_q;
    assign pick_start = IW'(wrap_inc(int'(pick_base), N_REQ));

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req   (req_i),
        .start (pick_start),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Owner word mux; zero whenever nobody owns the port.
    always_comb begin
        fifo_data_o = '0;
        if (state_q == BUSY) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (owner_q == IW'(k)) begin
                    fifo_data_o = data_i[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Next-state logic for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        beat_d      = beat_q;
        gnt_d       = gnt_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    owner_d = pick_idx;
                    beat_d  = '0;
                    gnt_d   = ONE_HOT0 << pick_idx;
                end
            end
            BUSY: begin
                // A dropped request releases without a beat, even when full.
                if (!owner_req) begin
                    release_now = 1'b1;
                end else if (!fifo_full_i) begin
                    beat_d = beat_inc;
                    if (beat_inc == BURST_LEN) begin
                        release_now = 1'b1;
                    end
                end
                if (release_now) begin
                    last_d = owner_q;
                    beat_d = '0;
                    if (pick_valid) begin
                        owner_d = pick_idx;
                        gnt_d   = ONE_HOT0 << pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Arbiter state registers; last_owner resets to N_REQ-1 so the first
    // grant after reset goes to requester 0 first.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_IDX;
            beat_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [N_REQ];
    logic [STAT_W-1:0] stat_d [N_REQ];

    // Saturating counters; clear wins over a same-cycle increment.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            stat_d[k] = stat_q[k];
            if (stats_clr_i) begin
                stat_d[k] = '0;
            end else if (ack_o[k] && (stat_q[k] != '1)) begin
                stat_d[k] = stat_q[k] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < N_REQ; k++) begin
                stat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                stat_q[k] <= stat_d[k];
            end
        end
    end

    always_comb begin
        stats_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            stats_o[k*STAT_W +: STAT_W] = stat_q[k];
        end
    end
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr_i;
    assign stats_o          = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb
// Self-checking bench for fifo_wr_arb with default parameters. A
// behavioural model (owner as an int, -1 when idle) predicts every
// output; directed scenarios also check fixed expected values.
// Build with FIFO_WR_ARB_STATS_EN defined to exercise the counters.
module tb_fifo_wr_arb;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int B  = 4;
    localparam int SW = 16;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [N*W-1:0] data_i = '0;
    logic           fifo_full_i = 1'b0;
    logic           stats_clr_i = 1'b0;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   ack_o;
    logic           fifo_wr_en_o;
    logic [W-1:0]   fifo_data_o;
    logic [N*SW-1:0] stats_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_owner;
    int m_beats;
    int m_last;
    int m_cnt [N];

    // Model predictions for the current cycle
    logic [N-1:0]    e_gnt;
    logic [N-1:0]    e_ack;
    logic            e_wr;
    logic [W-1:0]    e_data;
    logic [N*SW-1:0] e_stats;

    fifo_wr_arb #(.WIDTH(W), .N_REQ(N), .BURST(B)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .data_i       (data_i),
        .fifo_full_i  (fifo_full_i),
        .gnt_o        (gnt_o),
        .ack_o        (ack_o),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_data_o  (fifo_data_o),
        .stats_clr_i  (stats_clr_i),
        .stats_o      (stats_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int rr_first(input logic [N-1:0] r, input int start);
        for (int i = 0; i < N; i++) begin
            if (r[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = N - 1;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endfunction

    function automatic void model_outputs();
        e_gnt  = '0;
        e_ack  = '0;
        e_data = '0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_data = data_i[m_owner*W +: W];
            if (req_i[m_owner] && !fifo_full_i) e_ack = e_gnt;
        end
        e_wr = |e_ack;
        for (int k = 0; k < N; k++) e_stats[k*SW +: SW] = SW'(m_cnt[k]);
    endfunction

    // One clock edge of the specified behaviour.
    function automatic void model_advance();
        bit rel;
        model_outputs();
`ifdef FIFO_WR_ARB_STATS_EN
        for (int k = 0; k < N; k++) begin
            if (stats_clr_i) m_cnt[k] = 0;
            else if (e_ack[k] && m_cnt[k] < 65535) m_cnt[k]++;
        end
`endif
        if (m_owner < 0) begin
            if (req_i != '0) begin
                m_owner = rr_first(req_i, (m_last + 1) % N);
                m_beats = 0;
            end
        end else begin
            rel = 0;
            if (!req_i[m_owner]) rel = 1;
            else if (!fifo_full_i) begin
                m_beats++;
                if (m_beats == B) rel = 1;
            end
            if (rel) begin
                m_last  = m_owner;
                m_owner = rr_first(req_i, (m_last + 1) % N);
                m_beats = 0;
            end
        end
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic f, input logic c);
        req_i       = r;
        fifo_full_i = f;
        stats_clr_i = c;
        for (int k = 0; k < N; k++) data_i[k*W +: W] = $urandom;
        #1;
        model_outputs();
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rst_i) model_advance();
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        rst_i = 1'b0;
        model_reset();
        drive('0, 1'b0, 1'b0);
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 1'b0, 1'b0);
            total++; if (gnt_o !== 4'b0000) begin bad++; $display("[TB] FAIL rst_gnt got=%b exp=0000", gnt_o); end
            total++; if (ack_o !== 4'b0000) begin bad++; $display("[TB] FAIL rst_ack got=%b exp=0000", ack_o); end
            total++; if (fifo_wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_wr got=%b exp=0", fifo_wr_en_o); end
            total++; if (fifo_data_o !== '0) begin bad++; $display("[TB] FAIL rst_data got=%h exp=0", fifo_data_o); end
            total++; if (stats_o !== '0) begin bad++; $display("[TB] FAIL rst_stats got=%h exp=0", stats_o); end
            tick();
        end
        rst_i = 1'b1;
        drive(4'b1111, 1'b0, 1'b0);
        total++; if (gnt_o !== 4'b0000) begin bad++; $display("[TB] FAIL rst_idle_gnt got=%b exp=0000", gnt_o); end
        tick();
        drive(4'b1111, 1'b0, 1'b0);
        total++; if (gnt_o !== 4'b0001) begin bad++; $display("[TB] FAIL rst_first_gnt got=%b exp=0001", gnt_o); end
        total++; if (ack_o !== 4'b0001) begin bad++; $display("[TB] FAIL rst_first_ack got=%b exp=0001", ack_o); end
        tick();
    endtask

    task automatic test_sole_requester();
        int writes;
        writes = 0;
        apply_reset();
        drive(4'b0001, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 8; c++) begin
            drive(4'b0001, 1'b0, 1'b0);
            total++; if (gnt_o !== 4'b0001) begin bad++; $display("[TB] FAIL sole_gnt cyc=%0d got=%b exp=0001", c, gnt_o); end
            total++; if (fifo_data_o !== data_i[W-1:0]) begin bad++; $display("[TB] FAIL sole_data cyc=%0d got=%h exp=%h", c, fifo_data_o, data_i[W-1:0]); end
            if (fifo_wr_en_o === 1'b1) writes++;
            tick();
        end
        total++; if (writes != 8) begin bad++; $display("[TB] FAIL sole_writes got=%0d exp=8", writes); end
    endtask

    task automatic test_all_requesters();
        int order[$];
        int idx;
        apply_reset();
        drive(4'b1111, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 20; c++) begin
            drive(4'b1111, 1'b0, 1'b0);
            if (fifo_wr_en_o === 1'b1) begin
                idx = -1;
                for (int k = 0; k < N; k++) if (ack_o[k]) idx = k;
                order.push_back(idx);
                if (idx >= 0) begin
                    total++; if (fifo_data_o !== data_i[idx*W +: W]) begin bad++; $display("[TB] FAIL all_data cyc=%0d got=%h exp=%h", c, fifo_data_o, data_i[idx*W +: W]); end
                end
            end
            tick();
        end
        total++; if (order.size() != 20) begin bad++; $display("[TB] FAIL all_count got=%0d exp=20", order.size()); end
        for (int b = 0; b < order.size() && b < 20; b++) begin
            total++; if (order[b] != (b / 4) % 4) begin bad++; $display("[TB] FAIL all_order beat=%0d got=%0d exp=%0d", b, order[b], (b / 4) % 4); end
        end
    endtask

    task automatic test_full_stall();
        int n;
        int after;
        n = 0;
        after = 0;
        apply_reset();
        drive(4'b0100, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(4'b0110, 1'b0, 1'b0);
            if (ack_o[2] === 1'b1) n++;
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            drive(4'b0110, 1'b1, 1'b0);
            total++; if (gnt_o !== 4'b0100) begin bad++; $display("[TB] FAIL stall_gnt cyc=%0d got=%b exp=0100", c, gnt_o); end
            total++; if (ack_o !== 4'b0000) begin bad++; $display("[TB] FAIL stall_ack cyc=%0d got=%b exp=0000", c, ack_o); end
            total++; if (fifo_wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_wr cyc=%0d got=%b exp=0", c, fifo_wr_en_o); end
            tick();
        end
        while (n < 4 && after < 10) begin
            drive(4'b0110, 1'b0, 1'b0);
            if (ack_o[2] === 1'b1) n++;
            after++;
            tick();
        end
        total++; if (n != 4) begin bad++; $display("[TB] FAIL stall_beats got=%0d exp=4", n); end
        total++; if (after != 2) begin bad++; $display("[TB] FAIL stall_resume got=%0d exp=2", after); end
        drive(4'b0110, 1'b0, 1'b0);
        total++; if (gnt_o !== 4'b0010) begin bad++; $display("[TB] FAIL stall_next_gnt got=%b exp=0010", gnt_o); end
        tick();
    endtask

    task automatic test_drop_req();
        apply_reset();
        drive(4'b1010, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(4'b1010, 1'b0, 1'b0);
            total++; if (ack_o !== 4'b0010) begin bad++; $display("[TB] FAIL drop_ack cyc=%0d got=%b exp=0010", c, ack_o); end
            tick();
        end
        drive(4'b1000, 1'b0, 1'b0);
        total++; if (fifo_wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL drop_nobeat got=%b exp=0", fifo_wr_en_o); end
        tick();
        drive(4'b1000, 1'b0, 1'b0);
        total++; if (gnt_o !== 4'b1000) begin bad++; $display("[TB] FAIL drop_gnt got=%b exp=1000", gnt_o); end
        total++; if (fifo_wr_en_o !== 1'b1) begin bad++; $display("[TB] FAIL drop_nobubble got=%b exp=1", fifo_wr_en_o); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        drive(4'b1000, 1'b0, 1'b0);
        tick();
        drive(4'b1000, 1'b0, 1'b0);
        total++; if (gnt_o !== 4'b1000) begin bad++; $display("[TB] FAIL mid_gnt got=%b exp=1000", gnt_o); end
        tick();
        drive(4'b1000, 1'b0, 1'b0);
        rst_i = 1'b0;
        model_reset();
        #1;
        total++; if (gnt_o !== 4'b0000) begin bad++; $display("[TB] FAIL mid_rst_gnt got=%b exp=0000", gnt_o); end
        total++; if (fifo_wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_wr got=%b exp=0", fifo_wr_en_o); end
        total++; if (fifo_data_o !== '0) begin bad++; $display("[TB] FAIL mid_rst_data got=%h exp=0", fifo_data_o); end
        tick();
        drive(4'b1010, 1'b0, 1'b0);
        tick();
        rst_i = 1'b1;
        drive(4'b1010, 1'b0, 1'b0);
        total++; if (gnt_o !== 4'b0000) begin bad++; $display("[TB] FAIL mid_idle_gnt got=%b exp=0000", gnt_o); end
        tick();
        drive(4'b1010, 1'b0, 1'b0);
        total++; if (gnt_o !== 4'b0010) begin bad++; $display("[TB] FAIL mid_regrant got=%b exp=0010", gnt_o); end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        r = '0;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
            drive(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0));
            total++; if (gnt_o !== e_gnt) begin bad++; $display("[TB] FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, gnt_o, e_gnt); end
            total++; if (ack_o !== e_ack) begin bad++; $display("[TB] FAIL rnd_ack cyc=%0d got=%b exp=%b", c, ack_o, e_ack); end
            total++; if (fifo_wr_en_o !== e_wr) begin bad++; $display("[TB] FAIL rnd_wr cyc=%0d got=%b exp=%b", c, fifo_wr_en_o, e_wr); end
            total++; if (fifo_data_o !== e_data) begin bad++; $display("[TB] FAIL rnd_data cyc=%0d got=%h exp=%h", c, fifo_data_o, e_data); end
            total++; if (stats_o !== e_stats) begin bad++; $display("[TB] FAIL rnd_stats cyc=%0d got=%h exp=%h", c, stats_o, e_stats); end
            total++; if (!$onehot0(gnt_o) || (fifo_wr_en_o && fifo_full_i)) begin bad++; $display("[TB] FAIL rnd_invariant cyc=%0d gnt=%b wr=%b full=%b", c, gnt_o, fifo_wr_en_o, fifo_full_i); end
            tick();
        end
    endtask

    task automatic test_stats();
        apply_reset();
`ifdef FIFO_WR_ARB_STATS_EN
        for (int c = 0; c < 70010; c++) begin
            drive(4'b0001, 1'b0, 1'b0);
            tick();
        end
        drive(4'b0001, 1'b0, 1'b0);
        total++; if (stats_o[15:0] !== 16'hFFFF) begin bad++; $display("[TB] FAIL stats_sat got=%h exp=ffff", stats_o[15:0]); end
        total++; if (stats_o !== e_stats) begin bad++; $display("[TB] FAIL stats_model got=%h exp=%h", stats_o, e_stats); end
        total++; if (stats_o[N*SW-1:16] !== '0) begin bad++; $display("[TB] FAIL stats_others got=%h exp=0", stats_o[N*SW-1:16]); end
        tick();
        drive(4'b0001, 1'b0, 1'b1);
        total++; if (ack_o !== 4'b0001) begin bad++; $display("[TB] FAIL stats_clr_ack got=%b exp=0001", ack_o); end
        tick();
        drive(4'b0001, 1'b0, 1'b0);
        total++; if (stats_o[15:0] !== 16'h0000) begin bad++; $display("[TB] FAIL stats_clr got=%h exp=0000", stats_o[15:0]); end
        tick();
        drive(4'b0001, 1'b0, 1'b0);
        total++; if (stats_o[15:0] !== 16'h0001) begin bad++; $display("[TB] FAIL stats_incr got=%h exp=0001", stats_o[15:0]); end
        tick();
`else
        for (int c = 0; c < 12; c++) begin
            drive(4'b1111, 1'b0, 1'b0);
            tick();
        end
        drive(4'b1111, 1'b0, 1'b1);
        total++; if (stats_o !== '0) begin bad++; $display("[TB] FAIL stats_tied got=%h exp=0", stats_o); end
        tick();
        drive(4'b1111, 1'b0, 1'b0);
        total++; if (stats_o !== '0) begin bad++; $display("[TB] FAIL stats_tied_after got=%h exp=0", stats_o); end
        tick();
`endif
    endtask

    initial begin
        model_reset();
        $display("[TB] start");
        test_reset();
        test_sole_requester();
        test_all_requesters();
        test_full_stall();
        test_drop_req();
        test_reset_mid_burst();
        test_random();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
